// File: rtl/pipeline_control_unit.sv
`default_nettype none
// pipeline_control_unit: stall/flush sequencer for the five-stage pipeline, with
// memory-wait watchdog and saturating stall-cycle counter.  Rev 1.0
module pipeline_control_unit #(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   load_use_hazard,
  input  logic                   branch_taken,
  input  logic                   dmem_req,
  input  logic                   dmem_ready,
  input  logic                   mdu_start,
  input  logic                   mdu_done,
  input  logic                   halt_req,
  output logic                   stall_if,
  output logic                   stall_id,
  output logic                   stall_ex,
  output logic                   stall_mem,
  output logic                   flush_id,
  output logic                   flush_ex,
  output logic                   flush_mem,
  output logic                   pc_write_enable,
  output logic                   halted,
  output logic                   mem_timeout_error,
  output logic [1:0]             fsm_state,
  output logic [COUNT_WIDTH-1:0] stall_cycle_count
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd1,
    ST_MDU_WAIT = 2'd2,
    ST_HALT     = 2'd3
  } state_e;

  localparam logic [15:0]            TMO_LAST = 16'(MEM_TIMEOUT - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_ONE  = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                  state_q, state_d;
  logic [15:0]             tmo_q, tmo_d;
  logic                    err_q, err_d;
  logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    run_eval;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_RUN;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    run_eval  = 1'b0;
    stall_if  = 1'b0;
    stall_id  = 1'b0;
    stall_ex  = 1'b0;
    stall_mem = 1'b0;
    flush_id  = 1'b0;
    flush_ex  = 1'b0;
    flush_mem = 1'b0;

    case (state_q)
      ST_RUN: run_eval = 1'b1;
      ST_MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = ST_RUN;
        end else if (tmo_q == TMO_LAST) begin
          // Give up: drain the stuck access as a bubble rather than hold it.
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
          err_d     = 1'b1;
          state_d   = ST_RUN;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
          tmo_d     = tmo_q + 16'd1;
        end
      end
      ST_MDU_WAIT: begin
        if (mdu_done) begin
          state_d = ST_RUN;
        end else begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          flush_mem = 1'b1;
        end
      end
      ST_HALT: begin
        if (halt_req) begin
          stall_if  = 1'b1;
          stall_id  = 1'b1;
          stall_ex  = 1'b1;
          stall_mem = 1'b1;
        end else begin
          run_eval = 1'b1;
        end
      end
      default: run_eval = 1'b1;
    endcase

    if (run_eval) begin
      state_d = ST_RUN;
      if (dmem_req && !dmem_ready) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        tmo_d     = '0;
        state_d   = ST_MEM_WAIT;
      end else if (mdu_start && !mdu_done) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        flush_mem = 1'b1;
        state_d   = ST_MDU_WAIT;
      end else if (branch_taken) begin
        flush_id = 1'b1;
        flush_ex = 1'b1;
      end else if (load_use_hazard) begin
        stall_if = 1'b1;
        stall_id = 1'b1;
        flush_ex = 1'b1;
      end else if (halt_req) begin
        stall_if  = 1'b1;
        stall_id  = 1'b1;
        stall_ex  = 1'b1;
        stall_mem = 1'b1;
        state_d   = ST_HALT;
      end
    end

    // Controls must release the moment reset asserts, not at the next edge.
    if (!reset_n) begin
      stall_if  = 1'b0;
      stall_id  = 1'b0;
      stall_ex  = 1'b0;
      stall_mem = 1'b0;
      flush_id  = 1'b0;
      flush_ex  = 1'b0;
      flush_mem = 1'b0;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_if && (cnt_q != {COUNT_WIDTH{1'b1}})) cnt_d = cnt_q + CNT_ONE;
  end

  assign pc_write_enable   = !stall_if;
  assign halted            = (state_q == ST_HALT);
  assign mem_timeout_error = err_q;
  assign fsm_state         = state_q;
  assign stall_cycle_count = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_control_unit.sv
`default_nettype none
// tb_pipeline_control_unit: directed and randomized checks against a cycle-level
// reference model of the stall/flush rules.  Rev 1.0
module tb_pipeline_control_unit;

  localparam int unsigned MEM_TIMEOUT = 4;
  localparam int unsigned COUNT_WIDTH = 8;
  localparam int          CNT_MAX     = (1 << COUNT_WIDTH) - 1;

  logic clk = 1'b0;
  logic reset_n, load_use_hazard, branch_taken, dmem_req, dmem_ready;
  logic mdu_start, mdu_done, halt_req;
  logic stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem;
  logic pc_write_enable, halted, mem_timeout_error;
  logic [1:0] fsm_state;
  logic [COUNT_WIDTH-1:0] stall_cycle_count;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: mode uses the published fsm_state numbering.
  int m_mode, m_wait, m_cnt;
  bit m_err;

  pipeline_control_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .COUNT_WIDTH(COUNT_WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .load_use_hazard(load_use_hazard),
    .branch_taken(branch_taken), .dmem_req(dmem_req), .dmem_ready(dmem_ready),
    .mdu_start(mdu_start), .mdu_done(mdu_done), .halt_req(halt_req),
    .stall_if(stall_if), .stall_id(stall_id), .stall_ex(stall_ex), .stall_mem(stall_mem),
    .flush_id(flush_id), .flush_ex(flush_ex), .flush_mem(flush_mem),
    .pc_write_enable(pc_write_enable), .halted(halted),
    .mem_timeout_error(mem_timeout_error), .fsm_state(fsm_state),
    .stall_cycle_count(stall_cycle_count)
  );

  always #5 clk = ~clk;

  // Bit order {dmem_req, dmem_ready, mdu_start, mdu_done, branch, load_use, halt}.
  task automatic drive(input logic [6:0] v);
    {dmem_req, dmem_ready, mdu_start, mdu_done, branch_taken, load_use_hazard, halt_req} = v;
  endtask

  function automatic int run_rule();
    if (dmem_req && !dmem_ready) return 1;
    if (mdu_start && !mdu_done)  return 2;
    if (branch_taken)            return 3;
    if (load_use_hazard)         return 4;
    if (halt_req)                return 5;
    return 6;
  endfunction

  // Control bundle {stall_if,id,ex,mem, flush_id,ex,mem} for each RUN rule.
  function automatic logic [6:0] rule_ctrl(input int r);
    case (r)
      1:       return 7'b1111_000;
      2:       return 7'b1110_001;
      3:       return 7'b0000_110;
      4:       return 7'b1100_010;
      5:       return 7'b1111_000;
      default: return 7'b0000_000;
    endcase
  endfunction

  function automatic logic [6:0] exp_ctrl();
    if (!reset_n) return 7'b0;
    case (m_mode)
      0: return rule_ctrl(run_rule());
      1: begin
        if (dmem_ready) return 7'b0;
        if (m_wait == int'(MEM_TIMEOUT) - 1) return 7'b1110_001;
        return 7'b1111_000;
      end
      2: return mdu_done ? 7'b0 : 7'b1110_001;
      default: return halt_req ? 7'b1111_000 : rule_ctrl(run_rule());
    endcase
  endfunction

  function automatic logic [19:0] exp_vec();
    logic [6:0] c;
    c = exp_ctrl();
    return {c, ~c[6], (m_mode == 3), m_err, 2'(m_mode), 8'(m_cnt)};
  endfunction

  function automatic logic [19:0] obs_vec();
    return {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_mem,
            pc_write_enable, halted, mem_timeout_error, fsm_state, stall_cycle_count};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_wait = 0; m_cnt = 0; m_err = 1'b0;
  endtask

  // Advance the model across one rising edge using the inputs held at that edge.
  task automatic model_step();
    logic [6:0] c;
    int r;
    if (!reset_n) return;
    c = exp_ctrl();
    if (c[6] && m_cnt < CNT_MAX) m_cnt++;
    if (m_mode == 1) begin
      if (dmem_ready) m_mode = 0;
      else if (m_wait == int'(MEM_TIMEOUT) - 1) begin m_err = 1'b1; m_mode = 0; end
      else m_wait++;
    end else if (m_mode == 2) begin
      if (mdu_done) m_mode = 0;
    end else if (!(m_mode == 3 && halt_req)) begin
      r = run_rule();
      m_mode = (r == 1) ? 1 : (r == 2) ? 2 : (r == 5) ? 3 : 0;
      if (r == 1) m_wait = 0;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(7'b0);
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(7'b0); #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL reset cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      n_checks++;
      if (fsm_state !== 2'd0 || pc_write_enable !== 1'b1 || stall_cycle_count !== 8'd0) begin
        n_fail++; $display("FAIL reset_idle: got st=%0d pcwe=%b cnt=%0d want 0/1/0",
                           fsm_state, pc_write_enable, stall_cycle_count);
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  task automatic test_mem_wait();
    logic [6:0] seq [5] = '{7'b1000000, 7'b1000000, 7'b1000000, 7'b1100000, 7'b0000000};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(seq[i]); #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mem_wait cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      @(posedge clk); model_step(); #1;
    end
    n_checks++;
    if (stall_cycle_count !== 8'd3) begin
      n_fail++; $display("FAIL mem_wait_count: got %0d want 3", stall_cycle_count);
    end
  endtask

  task automatic test_mem_timeout();
    do_reset();
    for (int i = 0; i < 7; i++) begin
      drive(i < 5 ? 7'b1000000 : 7'b0000000); #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mem_timeout cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if (flush_mem !== 1'b1 || stall_mem !== 1'b0 || stall_if !== 1'b1) begin
          n_fail++; $display("FAIL timeout_cycle: got fm=%b sm=%b sif=%b want 1/0/1",
                             flush_mem, stall_mem, stall_if);
        end
      end
      @(posedge clk); model_step(); #1;
    end
    n_checks++;
    if (mem_timeout_error !== 1'b1) begin
      n_fail++; $display("FAIL timeout_sticky: got %b want 1", mem_timeout_error);
    end
  endtask

  task automatic test_mdu();
    int flushes = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(i == 0 ? 7'b0010000 : i == 5 ? 7'b0001000 : i == 7 ? 7'b0011000 : 7'b0);
      #3;
      if (flush_mem === 1'b1) flushes++;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL mdu cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      @(posedge clk); model_step(); #1;
    end
    n_checks++;
    if (flushes !== 5) begin
      n_fail++; $display("FAIL mdu_stall_len: got %0d want 5", flushes);
    end
  endtask

  task automatic test_branch();
    do_reset();
    drive(7'b0000110); #3;
    n_checks++;
    if ({flush_id, flush_ex, stall_if} !== 3'b110 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL branch_luh: got %h want %h", obs_vec(), exp_vec());
    end
    @(posedge clk); model_step(); #1;
    drive(7'b1000100); #3;
    n_checks++;
    if ({stall_if, stall_mem, flush_id, flush_ex} !== 4'b1100 || obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL branch_dmem: got %h want %h", obs_vec(), exp_vec());
    end
    @(posedge clk); model_step(); #1;
    drive(7'b0100000); #3;
    @(posedge clk); model_step(); #1;
  endtask

  task automatic test_halt();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(7'b0000001);
      if (i == 2) begin #2 reset_n = 1'b0; model_reset(); #1; end
      else #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL halt cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      if (i == 1) begin
        n_checks++;
        if (halted !== 1'b1) begin
          n_fail++; $display("FAIL halted_flag: got %b want 1", halted);
        end
      end
      @(posedge clk); model_step(); #1;
    end
    n_checks++;
    if (fsm_state !== 2'd0 || halted !== 1'b0 || stall_if !== 1'b0 || stall_cycle_count !== 8'd0) begin
      n_fail++; $display("FAIL halt_reset: got st=%0d h=%b sif=%b cnt=%0d want 0/0/0/0",
                         fsm_state, halted, stall_if, stall_cycle_count);
    end
    reset_n = 1'b1;
    drive(7'b0);
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 270; i++) begin
      drive(7'b0000001); #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL saturate cyc %0d: got %h want %h", i, obs_vec(), exp_vec());
      end
      @(posedge clk); model_step(); #1;
    end
    n_checks++;
    if (stall_cycle_count !== 8'hFF) begin
      n_fail++; $display("FAIL saturate_final: got %0d want 255", stall_cycle_count);
    end
    drive(7'b0);
    @(posedge clk); model_step(); #1;
  endtask

  task automatic test_random();
    logic [6:0] v;
    logic hreg = 1'b0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 24) == 0) hreg = ~hreg;
      v[6] = ($urandom_range(0, 9) < 3);
      v[5] = ($urandom_range(0, 1) == 1);
      v[4] = ($urandom_range(0, 9) < 2);
      v[3] = ($urandom_range(0, 9) < 3);
      v[2] = ($urandom_range(0, 9) < 2);
      v[1] = ($urandom_range(0, 9) < 2);
      v[0] = hreg;
      drive(v); #3;
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random cyc %0d in=%b: got %h want %h", i, v, obs_vec(), exp_vec());
      end
      @(posedge clk); model_step(); #1;
    end
  endtask

  initial begin
    reset_n = 1'b0;
    drive(7'b0);
    model_reset();
    test_reset();
    test_mem_wait();
    test_mem_timeout();
    test_mdu();
    test_branch();
    test_halt();
    test_saturate();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
